scan_out_ctrl: RTL and testbench

Display scan-out controller sitting directly downstream of the two frame buffers (buffer 0 / buffer 1). It generates raster timing (hsync, vsync, data-enable), drives the buffers' read address and per-buffer read enables, and realigns the 1-cycle-latency buffer read data with the timing signals to present one 24-bit pixel per clock. It also owns ping-pong buffer selection and swaps only on frame boundaries, at the writer's request.

---
 rtl/display_pkg.sv | 31 +++
 rtl/raster_timing_gen.sv | 72 +++++++
 rtl/scan_out_ctrl.sv | 132 +++++++++++++
 tb/tb_scan_out_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display timing defaults, pixel geometry and small sizing helpers
// for the frame-buffer scan-out path.
package display_pkg;

  localparam int unsigned PixW  = 24;
  localparam int unsigned ChanW = 8;

  localparam bit SyncActiveLow = 1'b0;

  localparam int unsigned DefHActive = 10;
  localparam int unsigned DefHFp     = 2;
  localparam int unsigned DefHSync   = 3;
  localparam int unsigned DefHBp     = 2;
  localparam int unsigned DefVActive = 10;
  localparam int unsigned DefVFp     = 1;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 1;
  localparam int unsigned DefAddrW   = 20;

  typedef enum logic [0:0] {StIdle, StRun} scan_state_e;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/raster_timing_gen.sv
// Horizontal/vertical raster counters with active-area, sync-window and
// end-of-frame decode; run state only changes at frame boundaries.
module raster_timing_gen
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic running_o,
  output logic active_o,
  output logic hsync_act_o,
  output logic vsync_act_o,
  output logic frame_end_o
);

  localparam int unsigned HTotal = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW     = cnt_width(HTotal);
  localparam int unsigned VW     = cnt_width(VTotal);

  scan_state_e   state_q;
  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  logic          h_last, v_last;

  assign h_last = (32'(h_q) == HTotal - 1);
  assign v_last = (32'(v_q) == VTotal - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (enable_i) state_q <= StRun;
        StRun: begin
          if (h_last) begin
            h_q <= '0;
            if (v_last) begin
              v_q <= '0;
              if (!enable_i) state_q <= StIdle;
            end else begin
              v_q <= v_q + 1'b1;
            end
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign running_o   = (state_q == StRun);
  assign active_o    = running_o && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
  assign hsync_act_o = running_o && (32'(h_q) >= H_ACTIVE + H_FP)
                       && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vsync_act_o = running_o && (32'(v_q) >= V_ACTIVE + V_FP)
                       && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
  assign frame_end_o = running_o && h_last && v_last;

endmodule

// File: rtl/scan_out_ctrl.sv
// Frame-buffer scan-out: raster timing, buffer read address/enables, ping-pong
// buffer selection swapped at frame boundaries, and 3-stage output alignment.
module scan_out_ctrl
  import display_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          SYNC_POL = SyncActiveLow
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              swap_req,
  input  logic [7:0]        b0_d0,
  input  logic [7:0]        b0_d1,
  input  logic [7:0]        b0_d2,
  input  logic [7:0]        b1_d0,
  input  logic [7:0]        b1_d1,
  input  logic [7:0]        b1_d2,
  output logic [ADDR_W-1:0] addr_read,
  output logic              re0,
  output logic              re1,
  output logic              rd_sel,
  output logic              swap_ack,
  output logic [PixW-1:0]   pix,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_done
);

  if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("scan_out_ctrl: ADDR_W too small for H_ACTIVE*V_ACTIVE");
  end

  logic running, active, hs_act, vs_act, frame_end;

  raster_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i       (clock),
    .rst_i       (reset),
    .enable_i    (enable),
    .running_o   (running),
    .active_o    (active),
    .hsync_act_o (hs_act),
    .vsync_act_o (vs_act),
    .frame_end_o (frame_end)
  );

  logic [ADDR_W-1:0] idx_q;
  logic              pend_q;
  logic              de1_q, hs1_q, vs1_q;
  logic              de2_q, hs2_q, vs2_q, sel2_q;
  logic              do_swap;
  logic [PixW-1:0]   b0_pix, b1_pix;

  assign do_swap    = frame_end & (pend_q | swap_req);
  assign b0_pix     = {b0_d2, b0_d1, b0_d0};
  assign b1_pix     = {b1_d2, b1_d1, b1_d0};
  assign frame_done = frame_end;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q     <= '0;
      addr_read <= '0;
      re0       <= 1'b0;
      re1       <= 1'b0;
      rd_sel    <= 1'b0;
      pend_q    <= 1'b0;
      swap_ack  <= 1'b0;
      de1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      de2_q     <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      sel2_q    <= 1'b0;
      de        <= 1'b0;
      pix       <= '0;
      hsync     <= ~SYNC_POL;
      vsync     <= ~SYNC_POL;
    end else begin
      // Linear pixel index tracked by increment; addr_read holds in blanking.
      if (frame_end) begin
        idx_q <= '0;
      end else if (active) begin
        addr_read <= idx_q;
        idx_q     <= idx_q + 1'b1;
      end
      re0   <= active & ~rd_sel;
      re1   <= active & rd_sel;
      de1_q <= active;
      hs1_q <= hs_act;
      vs1_q <= vs_act;

      // Buffer data lands one clock after re; sel2_q names its source buffer.
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      sel2_q <= re1;

      de    <= de2_q;
      pix   <= de2_q ? (sel2_q ? b1_pix : b0_pix) : '0;
      hsync <= hs2_q ? SYNC_POL : ~SYNC_POL;
      vsync <= vs2_q ? SYNC_POL : ~SYNC_POL;

      if (do_swap) begin
        rd_sel <= ~rd_sel;
        pend_q <= 1'b0;
      end else if (swap_req) begin
        pend_q <= 1'b1;
      end
      swap_ack <= do_swap;
    end
  end

endmodule

// File: tb/tb_scan_out_ctrl.sv
// Self-checking bench for scan_out_ctrl: a frame-position reference model
// predicts every output from the raster rules, driven by random stimulus.
module tb_scan_out_ctrl;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [23:0] B1Tag = 24'hA00000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        swap_req = 1'b0;
  logic [23:0] b0_q = '0;
  logic [23:0] b1_q = '0;
  logic [19:0] addr_read;
  logic        re0, re1, rd_sel, swap_ack, hsync, vsync, de, frame_done;
  logic [23:0] pix;

  always #5 clock = ~clock;

  scan_out_ctrl #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .ADDR_W   (20), .SYNC_POL (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .swap_req   (swap_req),
    .b0_d0      (b0_q[7:0]),
    .b0_d1      (b0_q[15:8]),
    .b0_d2      (b0_q[23:16]),
    .b1_d0      (b1_q[7:0]),
    .b1_d1      (b1_q[15:8]),
    .b1_d2      (b1_q[23:16]),
    .addr_read  (addr_read),
    .re0        (re0),
    .re1        (re1),
    .rd_sel     (rd_sel),
    .swap_ack   (swap_ack),
    .pix        (pix),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frame_done (frame_done)
  );

  // Buffers: one-clock read latency, buffer 1 tagged so its pixels are distinguishable.
  always @(posedge clock) begin
    if (re0) b0_q <= 24'(addr_read);
    if (re1) b1_q <= 24'(addr_read) ^ B1Tag;
  end

  logic [19:0] addr_m;
  logic [51:0] dut_vec;
  assign addr_m  = (re0 | re1) ? addr_read : 20'd0;
  assign dut_vec = {re0, re1, addr_m, rd_sel, swap_ack, frame_done, de, pix, hsync, vsync};

  // Model history: index 0 = counter position now, 1 = one clock ago, 3 = three ago.
  bit m_run[4];
  int m_pos[4];
  bit m_sel[4];
  bit m_pend, m_ack;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  task automatic tick();
    bit run, sel, fe;
    int pos;
    @(posedge clock);
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_pos[i] = 0; m_sel[i] = 0;
      end
      m_pend = 0;
      m_ack  = 0;
    end else begin
      run = m_run[0]; pos = m_pos[0]; sel = m_sel[0];
      fe = run && (pos == FT - 1);
      m_ack = fe && (m_pend || swap_req);
      if (m_ack) begin
        sel = !sel; m_pend = 0;
      end else if (swap_req) begin
        m_pend = 1;
      end
      if (!run) begin
        run = enable; pos = 0;
      end else if (pos == FT - 1) begin
        pos = 0; run = enable;
      end else begin
        pos++;
      end
      for (int i = 3; i > 0; i--) begin
        m_run[i] = m_run[i-1]; m_pos[i] = m_pos[i-1]; m_sel[i] = m_sel[i-1];
      end
      m_run[0] = run; m_pos[0] = pos; m_sel[0] = sel;
    end
    #1;
  endtask

  function automatic bit act(int i);
    return m_run[i] && (m_pos[i] % HT) < HA && (m_pos[i] / HT) < VA;
  endfunction

  function automatic int lin(int i);
    return (m_pos[i] / HT) * HA + (m_pos[i] % HT);
  endfunction

  function automatic logic [51:0] exp_vec();
    logic [23:0] p;
    logic        hs, vs;
    int          h3, v3;
    h3 = m_pos[3] % HT;
    v3 = m_pos[3] / HT;
    p  = !act(3) ? 24'd0 : (m_sel[3] ? (24'(lin(3)) ^ B1Tag) : 24'(lin(3)));
    hs = !(m_run[3] && h3 >= HA + HF && h3 < HA + HF + HS);
    vs = !(m_run[3] && v3 >= VA + VF && v3 < VA + VF + VS);
    return {act(1) && !m_sel[1], act(1) && m_sel[1], act(1) ? 20'(lin(1)) : 20'd0,
            m_sel[0], m_ack, m_run[0] && (m_pos[0] == FT - 1), act(3), p, hs, vs};
  endfunction

  task automatic test_reset();
    logic [51:0] want;
    reset = 1; enable = 0; swap_req = 0;
    tick(); tick();
    want = {2'b00, 20'd0, 4'b0000, 24'd0, 2'b11};
    n_tests++;
    if (dut_vec !== want) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec, want);
    end
    n_tests++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_scan();
    int last_fd = -1;
    int fd_cnt = 0;
    reset = 0; enable = 1;
    tick();
    for (int i = 0; i < 2 * FT + 4; i++) begin
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL scan cyc %0d: got %h want %h", cyc, dut_vec, exp_vec());
      end
      if (frame_done) begin
        fd_cnt++;
        if (last_fd >= 0) begin
          n_tests++;
          if (cyc - last_fd !== FT) begin
            n_fail++; $display("FAIL frame_period: got %0d want %0d", cyc - last_fd, FT);
          end
        end
        last_fd = cyc;
      end
    end
    n_tests++;
    if (fd_cnt !== 2) begin
      n_fail++; $display("FAIL frame_count: got %0d want 2", fd_cnt);
    end
  endtask

  task automatic test_pixels();
    int de_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      if (de) de_cnt++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL pixels cyc %0d: got %h want %h", cyc, dut_vec, exp_vec());
      end
      if (!de && pix !== 24'd0) begin
        n_tests++; n_fail++; $display("FAIL pix_blank: got %h want 0", pix);
      end
    end
    n_tests++;
    if (de_cnt !== HA * VA) begin
      n_fail++; $display("FAIL de_count: got %0d want %0d", de_cnt, HA * VA);
    end
  endtask

  task automatic wait_pos(input int target, input string tag);
    for (int i = 0; i < 2 * FT && !(m_run[0] && m_pos[0] == target); i++) tick();
    n_tests++;
    if (!(m_run[0] && m_pos[0] == target)) begin
      n_fail++; $display("FAIL %s_timeout: got pos %0d want %0d", tag, m_pos[0], target);
    end
  endtask

  task automatic test_swap_mid();
    logic s0;
    int   re0_seen = 0;
    wait_pos($urandom_range(8, 40), "swap_mid");
    s0 = rd_sel;
    swap_req = 1; tick(); swap_req = 0;
    wait_pos(FT - 1, "swap_mid_end");
    tick();
    n_tests++;
    if ({rd_sel, swap_ack} !== {~s0, 1'b1}) begin
      n_fail++; $display("FAIL swap_flip: got %b%b want %b1", rd_sel, swap_ack, ~s0);
    end
    for (int i = 0; i < FT - 1; i++) begin
      tick();
      if (re0 !== s0 && (re0 | re1)) re0_seen++;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL swap_frame cyc %0d: got %h want %h", cyc, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (re0_seen !== 0) begin
      n_fail++; $display("FAIL swap_old_buffer: got %0d reads want 0", re0_seen);
    end
  endtask

  task automatic test_swap_edge();
    logic s;
    wait_pos(FT - 1, "edge");
    s = rd_sel;
    swap_req = 1; tick(); swap_req = 0;
    n_tests++;
    if ({rd_sel, swap_ack} !== {~s, 1'b1}) begin
      n_fail++; $display("FAIL swap_edge_now: got %b%b want %b1", rd_sel, swap_ack, ~s);
    end
    wait_pos(FT - 1, "edge2");
    s = rd_sel;
    tick();
    swap_req = 1; tick(); swap_req = 0;
    n_tests++;
    if (rd_sel !== s) begin
      n_fail++; $display("FAIL swap_late_hold: got %b want %b", rd_sel, s);
    end
    wait_pos(FT - 1, "edge3");
    tick();
    n_tests++;
    if ({rd_sel, swap_ack} !== {~s, 1'b1}) begin
      n_fail++; $display("FAIL swap_late_apply: got %b%b want %b1", rd_sel, swap_ack, ~s);
    end
  endtask

  task automatic test_enable_drop();
    int          de_cnt = 0;
    int          idle_left = 5;
    logic [4:0]  idle_want;
    wait_pos(0, "drop");
    for (int i = 0; i < 2 * FT && idle_left > 0; i++) begin
      tick();
      if (m_pos[0] == 20) enable = 0;
      if (de) de_cnt++;
      if (!m_run[0]) idle_left--;
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL drop cyc %0d: got %h want %h", cyc, dut_vec, exp_vec());
      end
    end
    n_tests++;
    if (de_cnt !== HA * VA) begin
      n_fail++; $display("FAIL drop_pixels: got %0d want %0d", de_cnt, HA * VA);
    end
    idle_want = 5'b00011;
    n_tests++;
    if ({re0, re1, de, hsync, vsync} !== idle_want) begin
      n_fail++; $display("FAIL idle_outputs: got %b want %b", {re0, re1, de, hsync, vsync}, idle_want);
    end
    enable = 1;
    for (int i = 0; i < 8 && !(re0 | re1); i++) tick();
    n_tests++;
    if (!(re0 | re1) || addr_read !== 20'd0) begin
      n_fail++; $display("FAIL restart_addr: got re %b%b addr %0d want addr 0", re0, re1, addr_read);
    end
  endtask

  task automatic test_reset_mid();
    logic [51:0] want;
    wait_pos(HT + 2, "rst_mid");
    swap_req = 1; tick(); swap_req = 0;
    reset = 1; tick();
    want = {2'b00, 20'd0, 4'b0000, 24'd0, 2'b11};
    n_tests++;
    if (dut_vec !== want) begin
      n_fail++; $display("FAIL reset_mid: got %h want %h", dut_vec, want);
    end
    reset = 0; enable = 1;
    tick();
    wait_pos(FT - 1, "rst_frame");
    tick(); tick();
    n_tests++;
    if ({rd_sel, swap_ack} !== 2'b00) begin
      n_fail++; $display("FAIL pending_dropped: got %b%b want 00", rd_sel, swap_ack);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FT; i++) begin
      swap_req = ($urandom_range(0, 9) == 0);
      enable   = ($urandom_range(0, 19) != 0);
      tick();
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h want %h", cyc, dut_vec, exp_vec());
      end
    end
    swap_req = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pixels();
    test_swap_mid();
    test_swap_edge();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
